// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode stripe transmitter.
// Optional inter-frame gap is enabled by defining BARCODE_TX_GAP_EN.
package barcode_pkg;

    localparam int PERIOD_W    = 22;
    localparam int MIN_PERIOD  = 8;
    localparam int NUM_STRIPES = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } tx_state_t;

endpackage

// File: rtl/bc_seg_timer.sv
// Loadable segment down-counter: a load of N produces exactly N cycles before expire.
// Used by barcode_tx (BARCODE_TX_GAP_EN only changes what the top loads into it).
module bc_seg_timer #(
    parameter int PERIOD_W = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] len,
    output logic                expire
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    // The owner only loads while idle (count already 0) or in response to expire,
    // so a pending load never coincides with a count of 1 from another source.
    assign expire = (r_cnt == ONE);

endmodule

// File: rtl/barcode_tx.sv
// Pulse-width barcode transmitter: start stripe plus 8 data stripes, MSB first.
// Define BARCODE_TX_GAP_EN to append a 2*P high gap before done.
module barcode_tx #(
    parameter int PERIOD_W = barcode_pkg::PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                send,
    input  logic [7:0]          tx_id,
    input  logic [PERIOD_W-1:0] period,
    output logic                BC,
    output logic                busy,
    output logic                done
);

    import barcode_pkg::*;

    localparam logic [PERIOD_W-1:0] P_MIN      = PERIOD_W'(MIN_PERIOD);
    localparam logic [3:0]          LAST_STRIPE = 4'(NUM_STRIPES - 1);

    tx_state_t           r_state;
    tx_state_t           w_nstate;
    logic [7:0]          r_sh;
    logic                r_bit;
    logic [3:0]          r_stripe;
    logic [PERIOD_W-1:0] r_p;
    logic                r_bc;
    logic                r_busy;
    logic                r_done;

    logic                w_load;
    logic [PERIOD_W-1:0] w_len;
    logic                w_expire;
    logic                w_accept;
    logic                w_adv;
    logic                w_done;
    logic [PERIOD_W-1:0] w_pin;
    logic [PERIOD_W-1:0] w_q;
    logic [PERIOD_W-1:0] w_h;

    assign w_pin = (period < P_MIN) ? P_MIN : period;
    assign w_q   = r_p >> 2;
    assign w_h   = r_p >> 1;

    bc_seg_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .len    (w_len),
        .expire (w_expire)
    );

    always_comb begin
        w_nstate = r_state;
        w_load   = 1'b0;
        w_len    = '0;
        w_accept = 1'b0;
        w_adv    = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (send) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    w_len    = w_pin >> 1;
                    w_nstate = LOW;
                end
            end
            LOW: begin
                if (w_expire) begin
                    w_load   = 1'b1;
                    w_nstate = HIGH;
                    if (r_stripe == 4'd0)
                        w_len = r_p - w_h;
                    else if (r_bit)
                        w_len = r_p - w_q;
                    else
                        w_len = w_q;
                end
            end
            HIGH: begin
                if (w_expire) begin
                    if (r_stripe < LAST_STRIPE) begin
                        w_adv    = 1'b1;
                        w_load   = 1'b1;
                        w_nstate = LOW;
                        w_len    = r_sh[7] ? w_q : (r_p - w_q);
                    end else begin
`ifdef BARCODE_TX_GAP_EN
                        w_load   = 1'b1;
                        w_len    = r_p << 1;
                        w_nstate = GAP;
`else
                        w_done   = 1'b1;
                        w_nstate = IDLE;
`endif
                    end
                end
            end
`ifdef BARCODE_TX_GAP_EN
            GAP: begin
                if (w_expire) begin
                    w_done   = 1'b1;
                    w_nstate = IDLE;
                end
            end
`endif
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_bit    <= 1'b0;
            r_stripe <= '0;
            r_p      <= '0;
            r_bc     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_bc    <= (w_nstate != LOW);
            r_busy  <= (w_nstate != IDLE);
            r_done  <= w_done;
            if (w_accept) begin
                r_sh     <= tx_id;
                r_p      <= w_pin;
                r_stripe <= '0;
                r_bit    <= 1'b0;
            end else if (w_adv) begin
                // r_bit remembers the bit of the stripe now in flight for its high length
                r_bit    <= r_sh[7];
                r_sh     <= {r_sh[6:0], 1'b0};
                r_stripe <= r_stripe + 4'd1;
            end
        end
    end

    assign BC   = r_bc;
    assign busy = r_busy;
    assign done = r_done;

endmodule
